// File: rtl/pmod_ssd_decoder.sv
// pmod_ssd_decoder: snoops the multiplexed PmodSSD bus ({sel, seg[6:0]}),
// filters mux transitions, decodes both hex digits and emits them as a byte.
// Optional feature macro: SSD_DECODER_CHANGE_ONLY_EN (o_valid only when the
// decoded pair differs from the current o_value; first pair after reset always pulses).
module pmod_ssd_decoder #(
    parameter int PAR_STABLE_CYCLES  = 1000,
    parameter int PAR_TIMEOUT_CYCLES = 8_000_000
) (
    input  logic       i_clk_20mhz,
    input  logic       i_rst_20mhz,
    input  logic [7:0] i_ssd_pmod,
    output logic [7:0] o_value,
    output logic       o_valid,
    output logic       o_err,
    output logic       o_stale
);

    localparam int SW = $clog2(PAR_STABLE_CYCLES + 1);
    localparam int TW = $clog2(PAR_TIMEOUT_CYCLES + 1);

    typedef enum logic {S_IDLE, S_HAVE_D0} state_t;

    logic [7:0]    sync1, sync2, prev;
    logic [SW-1:0] stab_cnt;
    logic [TW-1:0] stale_cnt;
    logic          sample;
    logic          sel_edge;
    logic          sel;
    logic [6:0]    seg;
    logic          blank, legal;
    logic [3:0]    nib;
    logic [3:0]    digit0;
    state_t        state;

    // Segment pattern to nibble; legal=0 for anything that is not a hex glyph.
    always_comb begin
        legal = 1'b1;
        nib   = 4'h0;
        case (seg)
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h67: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    assign sel      = sync2[7];
    assign seg      = sync2[6:0];
    assign blank    = (seg == 7'h00);
    assign sel_edge = (sync2[7] != prev[7]);

    // The count is about to reach STABLE-1 on this edge: that is the single
    // sample point of a stable window, so outputs land STABLE+2 cycles after
    // the last input change.
    assign sample = (sync2 == prev) && (stab_cnt == SW'(PAR_STABLE_CYCLES - 2));

    assign o_stale = (stale_cnt == TW'(PAR_TIMEOUT_CYCLES));

    // Two-flop synchronizer plus previous-cycle copy for change detection.
    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            sync1 <= 8'h00;
            sync2 <= 8'h00;
            prev  <= 8'h00;
        end else begin
            sync1 <= i_ssd_pmod;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Stability counter: restart on any bus change, saturate at STABLE.
    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz)
            stab_cnt <= '0;
        else if (sync2 != prev)
            stab_cnt <= '0;
        else if (stab_cnt != SW'(PAR_STABLE_CYCLES))
            stab_cnt <= stab_cnt + 1'b1;
    end

    // Stale timer: a sel edge always wins over saturation.
    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz)
            stale_cnt <= '0;
        else if (sel_edge)
            stale_cnt <= '0;
        else if (stale_cnt != TW'(PAR_TIMEOUT_CYCLES))
            stale_cnt <= stale_cnt + 1'b1;
    end

`ifdef SSD_DECODER_CHANGE_ONLY_EN
    logic first_done;
    logic pair_new;
    assign pair_new = !first_done || ({nib, digit0} != o_value);
`endif

    // Pair-assembly FSM, advancing only on sample events; outputs registered.
    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            state   <= S_IDLE;
            digit0  <= 4'h0;
            o_value <= 8'h00;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
`ifdef SSD_DECODER_CHANGE_ONLY_EN
            first_done <= 1'b0;
`endif
        end else begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            if (sample) begin
                case (state)
                    S_IDLE: begin
                        if (blank) begin
                            state <= S_IDLE;
                        end else if (!legal) begin
                            o_err <= 1'b1;
                        end else if (!sel) begin
                            digit0 <= nib;
                            state  <= S_HAVE_D0;
                        end
                    end
                    S_HAVE_D0: begin
                        if (blank) begin
                            state <= S_IDLE;
                        end else if (!legal) begin
                            o_err <= 1'b1;
                            state <= S_IDLE;
                        end else if (!sel) begin
                            digit0 <= nib;
                        end else begin
                            o_value <= {nib, digit0};
`ifdef SSD_DECODER_CHANGE_ONLY_EN
                            o_valid    <= pair_new;
                            first_done <= 1'b1;
`else
                            o_valid <= 1'b1;
`endif
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pmod_ssd_decoder.sv
// Directed bench for pmod_ssd_decoder (STABLE=4, TIMEOUT=64).
module tb_pmod_ssd_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pmod = 8'h00;
    logic [7:0] o_value;
    logic       o_valid, o_err, o_stale;

    int checks = 0;
    int errors = 0;
    int nv = 0;
    int ne = 0;
    int nboth = 0;

    pmod_ssd_decoder #(.PAR_STABLE_CYCLES(4), .PAR_TIMEOUT_CYCLES(64)) dut (
        .i_clk_20mhz(clk),
        .i_rst_20mhz(rst),
        .i_ssd_pmod (pmod),
        .o_value    (o_value),
        .o_valid    (o_valid),
        .o_err      (o_err),
        .o_stale    (o_stale)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (o_valid) nv++;
        if (o_err) ne++;
        if (o_valid && o_err) nboth++;
    end

    typedef struct {
        logic [6:0] seg0;
        logic [6:0] seg1;
        int         exp_v;
        int         exp_e;
        logic [7:0] exp_val;
        string      name;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic s, input logic [6:0] sg, input int n);
        @(negedge clk);
        pmod = {s, sg};
        repeat (n) @(posedge clk);
    endtask

    task automatic pair(input logic [6:0] s0, input logic [6:0] s1);
        hold(1'b0, s0, 10);
        hold(1'b1, s1, 10);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int v0, e0;
        vecs[0]  = '{7'h5B, 7'h79, 1, 0, 8'hE2, "pair_E2"};
        vecs[1]  = '{7'h3F, 7'h06, 1, 0, 8'h10, "pair_10"};
        vecs[2]  = '{7'h4F, 7'h66, 1, 0, 8'h43, "pair_43"};
        vecs[3]  = '{7'h6D, 7'h7D, 1, 0, 8'h65, "pair_65"};
        vecs[4]  = '{7'h07, 7'h7F, 1, 0, 8'h87, "pair_87"};
        vecs[5]  = '{7'h67, 7'h77, 1, 0, 8'hA9, "pair_A9"};
        vecs[6]  = '{7'h7C, 7'h39, 1, 0, 8'hCB, "pair_CB"};
        vecs[7]  = '{7'h5E, 7'h79, 1, 0, 8'hED, "pair_ED"};
        vecs[8]  = '{7'h71, 7'h3F, 1, 0, 8'h0F, "pair_0F"};
        vecs[9]  = '{7'h01, 7'h06, 0, 1, 8'h0F, "illegal_d0"};
        vecs[10] = '{7'h3F, 7'h01, 0, 1, 8'h0F, "illegal_d1"};
        vecs[11] = '{7'h00, 7'h06, 0, 0, 8'h0F, "blank_d0"};
        vecs[12] = '{7'h3F, 7'h00, 0, 0, 8'h0F, "blank_d1"};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_value", o_value, 8'h00);
        check("rst_valid", o_valid, 1'b0);
        check("rst_err", o_err, 1'b0);
        check("rst_stale", o_stale, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Table of pairs.
        for (int i = 0; i < 13; i++) begin
            v0 = nv;
            e0 = ne;
            pair(vecs[i].seg0, vecs[i].seg1);
            check({vecs[i].name, "_valid"}, nv - v0, vecs[i].exp_v);
            check({vecs[i].name, "_err"}, ne - e0, vecs[i].exp_e);
            check({vecs[i].name, "_value"}, o_value, vecs[i].exp_val);
        end

        // Exact latency: final change to o_valid = 2 + STABLE cycles.
        hold(1'b0, 7'h06, 10);
        @(negedge clk);
        pmod = {1'b1, 7'h4F};
        repeat (5) @(posedge clk);
        #1;
        check("lat_early", o_valid, 1'b0);
        @(posedge clk);
        #1;
        check("lat_on_time", o_valid, 1'b1);
        check("lat_value", o_value, 8'h31);
        repeat (6) @(negedge clk);

        // Reset mid-pair discards digit0; outputs clear as reset asserts.
        hold(1'b0, 7'h7F, 10);
        @(negedge clk);
        pmod = {1'b1, 7'h06};
        #2 rst = 1'b1;
        #1;
        check("mid_rst_value", o_value, 8'h00);
        check("mid_rst_valid", o_valid, 1'b0);
        check("mid_rst_err", o_err, 1'b0);
        check("mid_rst_stale", o_stale, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        v0 = nv;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("mid_rst_no_valid", nv - v0, 0);

        // Illegal digit0 after reset: one error, value untouched.
        v0 = nv;
        e0 = ne;
        pair(7'h01, 7'h06);
        check("illegal_err", ne - e0, 1);
        check("illegal_no_valid", nv - v0, 0);
        check("illegal_value", o_value, 8'h00);

        // Bus toggling faster than the stable window: nothing samples.
        v0 = nv;
        e0 = ne;
        for (int i = 0; i < 34; i++)
            hold(1'b0, (i % 2 == 0) ? 7'h06 : 7'h4F, 3);
        @(negedge clk);
        check("toggle_no_valid", nv - v0, 0);
        check("toggle_no_err", ne - e0, 0);

        // Stale timer boundary and recovery.
        @(negedge clk);
        pmod = 8'h00;
        do_reset();
        repeat (63) @(posedge clk);
        #1;
        check("stale_63", o_stale, 1'b0);
        @(posedge clk);
        #1;
        check("stale_64", o_stale, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check("stale_70", o_stale, 1'b1);
        @(negedge clk);
        pmod = 8'h80;
        repeat (2) @(posedge clk);
        #1;
        check("stale_hold_2", o_stale, 1'b1);
        @(posedge clk);
        #1;
        check("stale_clear_3", o_stale, 1'b0);

        // First pair after reset always pulses, even 8'h00.
        do_reset();
        v0 = nv;
        pair(7'h3F, 7'h3F);
        check("first_00_valid", nv - v0, 1);
        check("first_00_value", o_value, 8'h00);

        // Repeated identical pair.
        do_reset();
        v0 = nv;
        pair(7'h5E, 7'h39);
        pair(7'h5E, 7'h39);
`ifdef SSD_DECODER_CHANGE_ONLY_EN
        check("repeat_valid", nv - v0, 1);
`else
        check("repeat_valid", nv - v0, 2);
`endif
        check("repeat_value", o_value, 8'hCD);

        check("valid_err_exclusive", nboth, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
